// File: rtl/usr_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : usr_shift_ctrl
//  Purpose  : Command sequencer for a WIDTH-bit universal shift register (USR).
//             Accepts one command per valid/ready handshake, optionally
//             parallel-loads the USR, then steers the USR select and serial
//             inputs for exactly N shift cycles and pulses done once the
//             USR contents are final. The USR itself lives outside.
//  Ports    : clk, rstn (async, active-low)
//             cmd_valid/cmd_ready      command handshake
//             cmd_op/load/amt/data     operation, load flag, count, load value
//             usr_q                    USR contents fed back for serial bits
//             usr_sel/pload            USR select (00 hold, 01 toward LSB,
//                                      10 toward MSB, 11 load) and load data
//             usr_lftin/usr_rghtin     serial inputs at LSB / MSB
//             busy, done, err          status; done/err are one-cycle pulses
//             abort                    only when USRCTL_ABORT_EN is defined
//  Options  : `define USRCTL_ABORT_EN adds the abort input.
//  Revision : 1.0  initial release
// ============================================================================
module usr_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [AW-1:0]    cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
`ifdef USRCTL_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_pload,
    output logic             usr_lftin,
    output logic             usr_rghtin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] c_op_nop = 3'b000;
    localparam logic [2:0] c_op_shl = 3'b001;
    localparam logic [2:0] c_op_shr = 3'b010;
    localparam logic [2:0] c_op_asr = 3'b011;
    localparam logic [2:0] c_op_rol = 3'b100;
    localparam logic [2:0] c_op_ror = 3'b101;

    localparam logic [1:0] c_sel_hold  = 2'b00;
    localparam logic [1:0] c_sel_right = 2'b01;
    localparam logic [1:0] c_sel_left  = 2'b10;
    localparam logic [1:0] c_sel_load  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic [AW-1:0]    r_cnt;      // latched amount, counts down in SHIFT
    logic             r_load;
    logic [WIDTH-1:0] r_pload;
    logic             r_abort;    // operation ended early by abort
    logic             w_accept;
    logic             w_abort;
    logic             w_unused_q;

    // 110/111 are the only illegal encodings.
    function automatic logic f_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // Legal and actually moves data (excludes NOP).
    function automatic logic f_is_shift(input logic [2:0] op);
        return (op != c_op_nop) && !f_illegal(op);
    endfunction

    assign w_accept = cmd_valid && (r_state == ST_IDLE);

`ifdef USRCTL_ABORT_EN
    assign w_abort = abort && ((r_state == ST_LOAD) || (r_state == ST_SHIFT));
`else
    assign w_abort = 1'b0;
`endif

    // Only the end bits of usr_q feed the serial inputs.
    assign w_unused_q = ^usr_q;

    // ------------------------------------------------------------------
    // State and command registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_op    <= 3'b000;
            r_cnt   <= '0;
            r_load  <= 1'b0;
            r_pload <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op    <= cmd_op;
                r_cnt   <= cmd_amt;
                r_load  <= cmd_load;
                r_pload <= cmd_data;
                r_abort <= 1'b0;
            end else if (w_abort) begin
                r_abort <= 1'b1;
            end else if (r_state == ST_SHIFT) begin
                r_cnt <= r_cnt - AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Illegal ops skip load and shift entirely.
                    if (f_illegal(cmd_op))
                        w_state_nxt = ST_DONE;
                    else if (cmd_load)
                        w_state_nxt = ST_LOAD;
                    else if (f_is_shift(cmd_op) && (cmd_amt != '0))
                        w_state_nxt = ST_SHIFT;
                    else
                        w_state_nxt = ST_DONE;
                end
            end
            ST_LOAD: begin
                if (!w_abort && f_is_shift(r_op) && (r_cnt != '0))
                    w_state_nxt = ST_SHIFT;
                else
                    w_state_nxt = ST_DONE;
            end
            ST_SHIFT: begin
                // r_cnt is never zero on entry, so leave after the last shift.
                if (w_abort || (r_cnt == AW'(1)))
                    w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // USR steering: combinational from state, latched op and usr_q so the
    // serial bit always matches the current USR contents.
    // ------------------------------------------------------------------
    always_comb begin
        usr_sel    = c_sel_hold;
        usr_lftin  = 1'b0;
        usr_rghtin = 1'b0;
        if ((r_state == ST_LOAD) && r_load && !w_abort) begin
            usr_sel = c_sel_load;
        end else if ((r_state == ST_SHIFT) && !w_abort) begin
            case (r_op)
                c_op_shl: usr_sel = c_sel_left;
                c_op_shr: usr_sel = c_sel_right;
                c_op_asr: begin
                    usr_sel    = c_sel_right;
                    usr_rghtin = usr_q[WIDTH-1];
                end
                c_op_rol: begin
                    usr_sel   = c_sel_left;
                    usr_lftin = usr_q[WIDTH-1];
                end
                c_op_ror: begin
                    usr_sel    = c_sel_right;
                    usr_rghtin = usr_q[0];
                end
                default: usr_sel = c_sel_hold;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = (r_state == ST_DONE) && (f_illegal(r_op) || r_abort);
    assign usr_pload = r_pload;

endmodule
`default_nettype wire

// File: doc/usr_shift_ctrl.md
Name: usr_shift_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit universal shift register: the 4-bit USR cell and its 8-bit cascades.
- Accepts one command per valid/ready handshake and optionally parallel-loads the register.
- Then drives the USR select/serial inputs for exactly N shift cycles and pulses done when the result is stable.
- Sits between a host/control FSM and the USR datapath; the USR itself stays outside this block.

Parameters:
- WIDTH, 8, USR data width (≥2).
- AW, 4, width of the shift-amount field.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  operation: 000 NOP/LOAD-only, 001 SHL, 010 SHR logical, 011 ASR, 100 ROL, 101 ROR, 110/111 illegal.
- cmd_load  input  1  1 = parallel-load cmd_data before shifting.
- cmd_amt  input  AW  shift count N.
- cmd_data  input  WIDTH  parallel-load value.
- usr_q  input  WIDTH  current USR contents (feedback).
- usr_sel  output  2  USR select: 00 hold, 01 shift toward LSB (rghtin enters MSB), 10 shift toward MSB (lftin enters LSB), 11 parallel load.
- usr_pload  output  WIDTH  USR parallel-load data.
- usr_lftin  output  1  serial input at LSB.
- usr_rghtin  output  1  serial input at MSB.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse; usr_q is valid while done=1.
- err  output  1  one-cycle pulse coincident with done for an illegal op.

Behaviour:
- Clock and reset: single clock clk; reset rstn is asynchronous, active-low.
- Reset values: state IDLE; cmd_ready=1; busy=0; done=0; err=0; usr_sel=00; usr_pload=0; latched op/amt/load cleared. usr_lftin/usr_rghtin evaluate to 0 in IDLE.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, usr_sel=00.
  - On cmd_valid&&cmd_ready: latch op, amt, load, and data into usr_pload.
  - Next state: LOAD if load=1; else SHIFT if amt≠0 and op legal; else DONE.
- LOAD:
  - usr_sel=11 for exactly one cycle; USR captures usr_pload on the exiting edge.
  - Next state: SHIFT if amt≠0 and op is a shift/rotate, else DONE.
- SHIFT:
  - Remaining-count register is loaded with amt at acceptance and decremented each SHIFT cycle. The controller stays in SHIFT for exactly amt cycles, then goes to DONE.
  - SHL: sel=10, lftin=0.
  - SHR: sel=01, rghtin=0.
  - ASR: sel=01, rghtin=usr_q[WIDTH-1].
  - ROL: sel=10, lftin=usr_q[WIDTH-1].
  - ROR: sel=01, rghtin=usr_q[0].
  - The unused serial input is 0.
  - Amounts ≥ WIDTH are performed literally: shifts fully clear or sign-fill; rotates wrap.
- DONE:
  - sel=00; done=1 for one cycle; err=1 if op was 110/111. Illegal ops never load or shift, even with cmd_load=1.
  - Next state: IDLE.
- Output timing: usr_sel, usr_lftin, and usr_rghtin are combinational from state, the latched op, and usr_q. usr_pload, busy, done, and err are registered/state-decoded.
- Handshake: cmd_ready=0 and busy=1 in LOAD/SHIFT/DONE. cmd_valid outside IDLE is ignored (not queued), and commands are not accepted in the DONE cycle.
- Latency: acceptance edge → done asserted = load + amt + 1 cycles. The minimum is 1 cycle (LOAD-only NOP, no load).
- Reset mid-operation: outputs return to reset values immediately and usr_sel=00 asynchronously. USR contents are left as-is.

Optional Feature:
- Macro: USRCTL_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 sampled in LOAD or SHIFT forces sel=00 that cycle and goes to DONE next, with done=1 and err=1. Remaining shifts are discarded and the partial result is left in the USR. abort is ignored in IDLE/DONE.
- Undefined: no abort port; commands always run to completion.

Test Plan:
All scenarios use WIDTH=8, AW=4, with a behavioural 8-bit USR attached.
1. Load-only: load=1, op=000, data=0xA5 → sel=11 for one cycle, done 2 cycles after acceptance, usr_q=0xA5, err=0.
2. SHL: load=1, data=0x81, op=001, amt=3 → sel=10 for exactly 3 cycles, done at cycle 5, usr_q=0x08.
3. Right shifts from load 0x80, amt=2: ASR → 0xE0; SHR → 0x20.
4. Rotates: ROL of 0x81 by 1 → 0x03. ROR of 0x01 by 9 → 0x80, taking 9 shift cycles.
5. Busy and reset:
   - Second cmd_valid pulsed while busy → ignored; only the first result appears.
   - rstn low mid-SHIFT → sel=00, cmd_ready=1 immediately; next command completes normally.
6. Illegal op: op=110, load=1 → no sel=11/01/10 cycles; done=err=1 one cycle after acceptance; usr_q unchanged.
